aurora_rx_checker: RTL and testbench

- AXI-Stream sink attached to the master (receive) interface of the augmented-Aurora module.
- Counterpart of the periodic two-word TX stimulus. Consumes received frames and checks each one against the expected constant frame {EXP_WORD0, EXP_WORD1}.
- Keeps saturating counts of good frames, data errors and length errors, and flags link silence with a watchdog.
- Used in the top-level demo and on hardware to confirm RTDS loopback and traffic integrity.

---
 rtl/aurora_rx_checker.sv | 204 ++++++++++++++++++++
 tb/tb_aurora_rx_checker.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aurora_rx_checker.sv
// aurora_rx_checker
// -----------------------------------------------------------------------------
// AXI-Stream sink for the receive side of the augmented-Aurora link. Every
// frame is checked against the constant two-word frame {EXP_WORD0, EXP_WORD1}
// sent by the periodic TX stimulus. The outcome is reported as a one-cycle
// frame_done pulse qualified by frame_ok. Saturating statistics counters track
// the results, and a watchdog flags a link that has gone silent.
//
// Ports
//   user_clk       in   Aurora user clock; all logic is on its rising edge
//   sys_reset_n    in   synchronous active-low reset
//   s_axis_tvalid  in   beat valid
//   s_axis_tdata   in   beat data (DATA_WIDTH)
//   s_axis_tlast   in   last beat of the frame
//   s_axis_tready  out  sink ready (registered, forced low by stall)
//   stall          in   test-only backpressure
//   clear_cnt      in   synchronous clear of the counters and word captures
//   frame_done     out  one-cycle pulse per completed frame
//   frame_ok       out  qualifies frame_done: 1 = frame matched
//   good_cnt       out  frames that matched
//   data_err_cnt   out  correct-length frames with a word mismatch
//   len_err_cnt    out  frames whose length is not 2
//   last_word0     out  beat 0 of the most recent frame
//   last_word1     out  beat 1 of the most recent frame (0 for 1-beat frames)
//   link_timeout   out  no frame completed within TIMEOUT_CYCLES
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module aurora_rx_checker #(
   parameter int                    DATA_WIDTH     = 32,
   parameter logic [DATA_WIDTH-1:0] EXP_WORD0      = 'h0000_0005,
   parameter logic [DATA_WIDTH-1:0] EXP_WORD1      = 'h0000_0003,
   parameter int                    CNT_WIDTH      = 16,
   parameter int                    TIMEOUT_CYCLES = 1024
) (
   input  logic                  user_clk,
   input  logic                  sys_reset_n,
   input  logic                  s_axis_tvalid,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tlast,
   output logic                  s_axis_tready,
   input  logic                  stall,
   input  logic                  clear_cnt,
   output logic                  frame_done,
   output logic                  frame_ok,
   output logic [CNT_WIDTH-1:0]  good_cnt,
   output logic [CNT_WIDTH-1:0]  data_err_cnt,
   output logic [CNT_WIDTH-1:0]  len_err_cnt,
   output logic [DATA_WIDTH-1:0] last_word0,
   output logic [DATA_WIDTH-1:0] last_word1,
   output logic                  link_timeout
);

   localparam int                WD_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WD_W-1:0]   WD_MAX = WD_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WD_W-1:0]   WD_ONE = {{(WD_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE,
      S_BEAT1,
      S_DRAIN
   } state_t;

   state_t                  state_q,        state_d;
   logic                    mismatch_q,     mismatch_d;
   logic                    tready_q,       tready_d;
   logic                    frame_done_q,   frame_done_d;
   logic                    frame_ok_q,     frame_ok_d;
   logic [CNT_WIDTH-1:0]    good_cnt_q,     good_cnt_d;
   logic [CNT_WIDTH-1:0]    data_err_cnt_q, data_err_cnt_d;
   logic [CNT_WIDTH-1:0]    len_err_cnt_q,  len_err_cnt_d;
   logic [DATA_WIDTH-1:0]   last_word0_q,   last_word0_d;
   logic [DATA_WIDTH-1:0]   last_word1_q,   last_word1_d;
   logic [WD_W-1:0]         wdog_q,         wdog_d;

   logic beat;
   logic done;
   logic ok;
   logic data_err;
   logic len_err;

   // Counters stick at all-ones instead of wrapping.
   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + CNT_ONE;
   endfunction

   always_comb begin
      beat         = s_axis_tvalid & tready_q;
      state_d      = state_q;
      mismatch_d   = mismatch_q;
      last_word0_d = last_word0_q;
      last_word1_d = last_word1_q;
      done         = 1'b0;
      ok           = 1'b0;
      data_err     = 1'b0;
      len_err      = 1'b0;

      if (beat) begin
         case (state_q)
            S_IDLE: begin
               last_word0_d = s_axis_tdata;
               if (s_axis_tlast) begin
                  // One-beat frame: length error, no beat 1 to report.
                  last_word1_d = '0;
                  done         = 1'b1;
                  len_err      = 1'b1;
               end else begin
                  mismatch_d = (s_axis_tdata != EXP_WORD0);
                  state_d    = S_BEAT1;
               end
            end
            S_BEAT1: begin
               last_word1_d = s_axis_tdata;
               if (s_axis_tlast) begin
                  done = 1'b1;
                  if (!mismatch_q && (s_axis_tdata == EXP_WORD1)) begin
                     ok = 1'b1;
                  end else begin
                     data_err = 1'b1;
                  end
                  state_d = S_IDLE;
               end else begin
                  state_d = S_DRAIN;
               end
            end
            S_DRAIN: begin
               // Over-long frame: swallow beats until tlast, then count it
               // as a length error regardless of content.
               if (s_axis_tlast) begin
                  done    = 1'b1;
                  len_err = 1'b1;
                  state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      tready_d     = ~stall;
      frame_done_d = done;
      frame_ok_d   = ok;

      // A clear on the same edge as an increment wins; the result is lost.
      good_cnt_d     = ok       ? sat_inc(good_cnt_q)     : good_cnt_q;
      data_err_cnt_d = data_err ? sat_inc(data_err_cnt_q) : data_err_cnt_q;
      len_err_cnt_d  = len_err  ? sat_inc(len_err_cnt_q)  : len_err_cnt_q;
      if (clear_cnt) begin
         good_cnt_d     = '0;
         data_err_cnt_d = '0;
         len_err_cnt_d  = '0;
         last_word0_d   = '0;
         last_word1_d   = '0;
      end

      // Reloading on the completing edge makes link_timeout drop together
      // with the frame_done pulse.
      if (done) begin
         wdog_d = '0;
      end else if (wdog_q == WD_MAX) begin
         wdog_d = wdog_q;
      end else begin
         wdog_d = wdog_q + WD_ONE;
      end
   end

   always_ff @(posedge user_clk) begin
      if (!sys_reset_n) begin
         state_q        <= S_IDLE;
         mismatch_q     <= 1'b0;
         tready_q       <= 1'b0;
         frame_done_q   <= 1'b0;
         frame_ok_q     <= 1'b0;
         good_cnt_q     <= '0;
         data_err_cnt_q <= '0;
         len_err_cnt_q  <= '0;
         last_word0_q   <= '0;
         last_word1_q   <= '0;
         wdog_q         <= '0;
      end else begin
         state_q        <= state_d;
         mismatch_q     <= mismatch_d;
         tready_q       <= tready_d;
         frame_done_q   <= frame_done_d;
         frame_ok_q     <= frame_ok_d;
         good_cnt_q     <= good_cnt_d;
         data_err_cnt_q <= data_err_cnt_d;
         len_err_cnt_q  <= len_err_cnt_d;
         last_word0_q   <= last_word0_d;
         last_word1_q   <= last_word1_d;
         wdog_q         <= wdog_d;
      end
   end

   assign s_axis_tready = tready_q;
   assign frame_done    = frame_done_q;
   assign frame_ok      = frame_ok_q;
   assign good_cnt      = good_cnt_q;
   assign data_err_cnt  = data_err_cnt_q;
   assign len_err_cnt   = len_err_cnt_q;
   assign last_word0    = last_word0_q;
   assign last_word1    = last_word1_q;
   assign link_timeout  = (wdog_q == WD_MAX);

endmodule

// File: tb/tb_aurora_rx_checker.sv
// Testbench for aurora_rx_checker. A second instance with 2-bit counters
// shares the stimulus so that counter saturation is reachable quickly.
`timescale 1ns/1ps
module tb_aurora_rx_checker;

   localparam int DW = 32;
   localparam int CW = 16;

   typedef struct packed {
      logic          ok;
      logic [DW-1:0] w0;
      logic [DW-1:0] w1;
   } exp_t;

   typedef struct {
      int             n;
      logic [3:0][31:0] w;
      int             kind;   // 0 good, 1 data error, 2 length error
      logic [31:0]    exp_w1;
   } vec_t;

   logic          user_clk = 1'b0;
   logic          sys_reset_n = 1'b0;
   logic          s_axis_tvalid = 1'b0;
   logic [DW-1:0] s_axis_tdata = '0;
   logic          s_axis_tlast = 1'b0;
   logic          stall = 1'b0;
   logic          clear_cnt = 1'b0;

   logic          s_axis_tready, frame_done, frame_ok, link_timeout;
   logic [CW-1:0] good_cnt, data_err_cnt, len_err_cnt;
   logic [DW-1:0] last_word0, last_word1;

   logic          s_tready, s_done, s_ok, s_timeout;
   logic [1:0]    s_good, s_derr, s_lerr;
   logic [DW-1:0] s_w0, s_w1;

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   done_cnt = 0;
   int   done_cyc[$];
   exp_t exp_q[$];
   exp_t mon_e;

   always #5 user_clk = ~user_clk;
   always @(posedge user_clk) cyc <= cyc + 1;

   aurora_rx_checker #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(1024)) dut (
      .user_clk(user_clk), .sys_reset_n(sys_reset_n),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata),
      .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
      .stall(stall), .clear_cnt(clear_cnt),
      .frame_done(frame_done), .frame_ok(frame_ok),
      .good_cnt(good_cnt), .data_err_cnt(data_err_cnt), .len_err_cnt(len_err_cnt),
      .last_word0(last_word0), .last_word1(last_word1),
      .link_timeout(link_timeout));

   aurora_rx_checker #(.DATA_WIDTH(DW), .CNT_WIDTH(2), .TIMEOUT_CYCLES(1024)) dut_sat (
      .user_clk(user_clk), .sys_reset_n(sys_reset_n),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata),
      .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_tready),
      .stall(stall), .clear_cnt(clear_cnt),
      .frame_done(s_done), .frame_ok(s_ok),
      .good_cnt(s_good), .data_err_cnt(s_derr), .len_err_cnt(s_lerr),
      .last_word0(s_w0), .last_word1(s_w1),
      .link_timeout(s_timeout));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_cnt(input string tag, input int g, input int d, input int l);
      chk({tag, ".good_cnt"}, 32'(good_cnt), g);
      chk({tag, ".data_err_cnt"}, 32'(data_err_cnt), d);
      chk({tag, ".len_err_cnt"}, 32'(len_err_cnt), l);
   endtask

   // Scoreboard: every frame_done pops the expectation pushed with its tlast.
   always @(negedge user_clk) begin
      if (frame_done === 1'b1) begin
         done_cnt++;
         done_cyc.push_back(cyc);
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_frame_done: got pulse at cycle %0d expected none", cyc);
         end else begin
            mon_e = exp_q.pop_front();
            chk("sb.frame_ok", 32'(frame_ok), 32'(mon_e.ok));
            chk("sb.last_word0", last_word0, mon_e.w0);
            chk("sb.last_word1", last_word1, mon_e.w1);
         end
      end
   end

   // Present one beat and hold it until the handshake edge has passed.
   task automatic beat(input logic [31:0] d, input logic last);
      int   n;
      logic rdy;
      n = 0;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = d;
      s_axis_tlast  = last;
      forever begin
         rdy = s_axis_tready;
         @(posedge user_clk);
         #1;
         if (rdy) break;
         n++;
         if (n > 200) begin
            total++;
            bad++;
            $display("FAIL handshake_timeout: got tready=0 for %0d cycles expected 1", n);
            break;
         end
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   task automatic send_frame(input int n, input logic [3:0][31:0] w, input exp_t e);
      for (int i = 0; i < n; i++) begin
         if (i == n - 1) exp_q.push_back(e);
         beat(w[i], (i == n - 1));
      end
   endtask

   function automatic exp_t mk(input logic ok, input logic [31:0] w0, input logic [31:0] w1);
      exp_t e;
      e.ok = ok;
      e.w0 = w0;
      e.w1 = w1;
      return e;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "simulation time limit");
   end

   initial begin
      vec_t tbl[9];
      int   eg, ed, el, d0;
      logic [3:0][31:0] f53;
      f53 = {32'd0, 32'd0, 32'd3, 32'd5};

      tbl[0] = '{2, {32'd0, 32'd0, 32'd4, 32'd5}, 1, 32'd4};
      tbl[1] = '{1, {32'd0, 32'd0, 32'd0, 32'd5}, 2, 32'd0};
      tbl[2] = '{3, {32'd0, 32'd7, 32'd3, 32'd5}, 2, 32'd3};
      tbl[3] = '{2, {32'd0, 32'd0, 32'd3, 32'd6}, 1, 32'd3};
      tbl[4] = '{2, {32'd0, 32'd0, 32'd3, 32'd5}, 0, 32'd3};
      tbl[5] = '{4, {32'd3, 32'd3, 32'd3, 32'd5}, 2, 32'd3};
      tbl[6] = '{1, {32'd0, 32'd0, 32'd0, 32'd9}, 2, 32'd0};
      tbl[7] = '{3, {32'd0, 32'd3, 32'd9, 32'd6}, 2, 32'd9};
      tbl[8] = '{1, {32'd0, 32'd0, 32'd0, 32'd3}, 2, 32'd0};

      // Reset state
      repeat (3) @(posedge user_clk);
      #1;
      chk("rst.tready", 32'(s_axis_tready), 0);
      chk("rst.frame_done", 32'(frame_done), 0);
      chk("rst.frame_ok", 32'(frame_ok), 0);
      chk_cnt("rst", 0, 0, 0);
      chk("rst.last_word0", last_word0, 0);
      chk("rst.last_word1", last_word1, 0);
      chk("rst.link_timeout", 32'(link_timeout), 0);

      // Watchdog runs from reset release with no traffic
      sys_reset_n = 1'b1;
      @(posedge user_clk);
      #1;
      chk("tready_after_release", 32'(s_axis_tready), 1);
      repeat (1021) @(posedge user_clk);
      #1;
      chk("timeout_at_1022", 32'(link_timeout), 0);
      @(posedge user_clk);
      #1;
      chk("timeout_at_1023", 32'(link_timeout), 1);
      beat(32'd5, 1'b0);
      chk("timeout_midframe", 32'(link_timeout), 1);
      exp_q.push_back(mk(1'b1, 32'd5, 32'd3));
      beat(32'd3, 1'b1);
      chk("timeout_frame_done", 32'(frame_done), 1);
      chk("timeout_falls_with_done", 32'(link_timeout), 0);

      // Standalone clear
      @(posedge user_clk);
      #1;
      clear_cnt = 1'b1;
      @(posedge user_clk);
      #1;
      clear_cnt = 1'b0;
      chk_cnt("clear_idle", 0, 0, 0);
      chk("clear_idle.last_word0", last_word0, 0);

      // Ten good frames spaced 258 cycles
      d0 = done_cnt;
      for (int i = 0; i < 10; i++) begin
         send_frame(2, f53, mk(1'b1, 32'd5, 32'd3));
         repeat (256) @(posedge user_clk);
         #1;
      end
      chk_cnt("ten_good", 10, 0, 0);
      chk("ten_good.last_word0", last_word0, 5);
      chk("ten_good.last_word1", last_word1, 3);
      chk("ten_good.pulses", done_cnt - d0, 10);
      chk("sat.good_cnt", 32'(s_good), 3);
      chk("ten_good.timeout", 32'(link_timeout), 0);

      // Table-driven frames
      eg = 10; ed = 0; el = 0;
      for (int i = 0; i < 9; i++) begin
         send_frame(tbl[i].n, tbl[i].w, mk(tbl[i].kind == 0, tbl[i].w[0], tbl[i].exp_w1));
         if (tbl[i].kind == 0) eg++;
         else if (tbl[i].kind == 1) ed++;
         else el++;
         repeat (2) @(posedge user_clk);
         #1;
         chk_cnt($sformatf("vec%0d", i), eg, ed, el);
      end
      chk("sat.data_err_cnt", 32'(s_derr), 2);
      chk("sat.len_err_cnt", 32'(s_lerr), 3);
      chk("sat.good_cnt_hold", 32'(s_good), 3);

      // Back-to-back frames, tvalid high for 6 cycles
      done_cyc.delete();
      d0 = cyc;
      for (int i = 0; i < 3; i++) send_frame(2, f53, mk(1'b1, 32'd5, 32'd3));
      repeat (3) @(posedge user_clk);
      #1;
      eg += 3;
      chk_cnt("b2b", eg, ed, el);
      chk("b2b.pulses", done_cyc.size(), 3);
      for (int i = 0; i < 3; i++) begin
         if (i < done_cyc.size()) chk($sformatf("b2b.done_cycle%0d", i), done_cyc[i] - d0, 2 * (i + 1));
      end

      // Stall mid-frame
      beat(32'd5, 1'b0);
      stall = 1'b1;
      @(posedge user_clk);
      #1;
      chk("stall.tready0", 32'(s_axis_tready), 0);
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 32'd3;
      s_axis_tlast  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge user_clk);
         #1;
         chk($sformatf("stall.tready%0d", i + 1), 32'(s_axis_tready), 0);
      end
      chk("stall.no_done", 32'(frame_done), 0);
      stall = 1'b0;
      @(posedge user_clk);
      #1;
      exp_q.push_back(mk(1'b1, 32'd5, 32'd3));
      beat(32'd3, 1'b1);
      chk("stall.frame_done", 32'(frame_done), 1);
      eg++;
      chk_cnt("stall", eg, ed, el);

      // Clear coinciding with a good-frame completion
      @(posedge user_clk);
      #1;
      beat(32'd5, 1'b0);
      exp_q.push_back(mk(1'b1, 32'd0, 32'd0));
      clear_cnt = 1'b1;
      beat(32'd3, 1'b1);
      clear_cnt = 1'b0;
      chk("clear_hit.frame_done", 32'(frame_done), 1);
      chk_cnt("clear_hit", 0, 0, 0);
      chk("clear_hit.sat_len", 32'(s_lerr), 0);

      // Reset mid-frame discards the partial frame
      repeat (2) @(posedge user_clk);
      #1;
      send_frame(2, f53, mk(1'b1, 32'd5, 32'd3));
      @(posedge user_clk);
      #1;
      chk_cnt("pre_reset", 1, 0, 0);
      beat(32'd5, 1'b0);
      sys_reset_n = 1'b0;
      @(posedge user_clk);
      #1;
      chk_cnt("mid_reset", 0, 0, 0);
      chk("mid_reset.tready", 32'(s_axis_tready), 0);
      chk("mid_reset.last_word0", last_word0, 0);
      chk("mid_reset.last_word1", last_word1, 0);
      chk("mid_reset.frame_done", 32'(frame_done), 0);
      sys_reset_n = 1'b1;
      @(posedge user_clk);
      #1;
      send_frame(2, f53, mk(1'b1, 32'd5, 32'd3));
      repeat (2) @(posedge user_clk);
      #1;
      chk_cnt("post_reset", 1, 0, 0);

      repeat (5) @(posedge user_clk);
      #1;
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
